// File: rtl/dmpsk_pkg.sv
// Shared types and helpers for the DMPSK modulator: FSM states, Gray decode,
// default carrier constants and the cosine table generator.
package dmpsk_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int  DEFAULT_FCW = 6554;
    localparam int  DEFAULT_SPS = 50;
    localparam real PI          = 3.14159265358979323846;

    // Gray-to-binary for up to 4 bits; narrower symbols are zero-extended first.
    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Elaboration-time table entry, rounded half away from zero.
    function automatic int cos_sample(input int addr, input int lut_aw, input int amp_w);
        real v;
        v = real'((1 << amp_w) - 1) * $cos(2.0 * PI * real'(addr) / real'(1 << lut_aw));
        if (v >= 0.0) begin
            return $rtoi(v + 0.5);
        end else begin
            return -$rtoi(0.5 - v);
        end
    endfunction

endpackage

// File: rtl/dmpsk_cos_lut.sv
// Registered cosine ROM: phase address in, signed amplitude out one cycle later.
module dmpsk_cos_lut
    import dmpsk_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int AMP_W  = 8
) (
    input  logic                     clk_dds,
    input  logic                     rstn,
    input  logic [LUT_AW-1:0]        i_addr,
    output logic signed [AMP_W:0]    o_q
);

    logic signed [AMP_W:0] w_rom [2**LUT_AW];
    logic signed [AMP_W:0] r_q;

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
        localparam int VAL = cos_sample(g, LUT_AW, AMP_W);
        assign w_rom[g] = (AMP_W+1)'(VAL);
    end

    // ROM read register; cleared on reset so an aborted symbol leaves no residue
    always_ff @(posedge clk_dds or negedge rstn) begin
        if (!rstn) begin
            r_q <= {(AMP_W+1){1'b0}};
        end else begin
            r_q <= w_rom[i_addr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dmpsk_modulator.sv
// Differential M-PSK modulator: free-running DDS carrier offset by the accumulated
// symbol phase. Define DMPSK_GRAY_MAP_EN to Gray-decode incoming symbols.
module dmpsk_modulator
    import dmpsk_pkg::*;
#(
    parameter int SYM_BITS = 2,
    parameter int PHASE_W  = 16,
    parameter int LUT_AW   = 8,
    parameter int AMP_W    = 8,
    parameter int SPS      = DEFAULT_SPS,
    parameter int FCW      = DEFAULT_FCW
) (
    input  logic                    clk_dds,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SYM_BITS-1:0]     in_data,
    output logic [SYM_BITS-1:0]     diff_out,
    output logic signed [AMP_W:0]   data_modul_out,
    output logic                    data_valid,
    output logic                    underrun
);

    localparam int CNT_W = (SPS > 2) ? $clog2(SPS) : 1;

    logic [PHASE_W-1:0]    r_acc;
    state_e                r_state;
    state_e                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [SYM_BITS-1:0]   r_diff;
    logic [SYM_BITS-1:0]   w_diff_nxt;
    logic [SYM_BITS-1:0]   w_map;
    logic                  w_last;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_underrun;
    logic [PHASE_W-1:0]    w_phase;
    logic signed [AMP_W:0] w_lut_q;
    logic                  r_vld1;
    logic                  r_vld2;
    logic signed [AMP_W:0] r_out;

`ifdef DMPSK_GRAY_MAP_EN
    assign w_map = SYM_BITS'(gray2bin(4'(in_data)));
`else
    assign w_map = in_data;
`endif

    assign w_last  = (r_state == ST_RUN) && (r_cnt == CNT_W'(SPS - 1));
    assign w_ready = (r_state == ST_IDLE) || w_last;
    assign w_xfer  = in_valid && w_ready;

    // Carrier phase accumulator, free-running from reset release
    always_ff @(posedge clk_dds or negedge rstn) begin
        if (!rstn) begin
            r_acc <= {PHASE_W{1'b0}};
        end else begin
            r_acc <= r_acc + PHASE_W'(FCW);
        end
    end

    // Symbol FSM state, sample counter and differential phase register
    always_ff @(posedge clk_dds or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_diff  <= {SYM_BITS{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_diff  <= w_diff_nxt;
        end
    end

    // Next-state logic: a transfer always restarts the symbol slot
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_diff_nxt  = r_diff;
        w_underrun  = 1'b0;
        if (w_xfer) begin
            w_diff_nxt  = r_diff + w_map;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                        w_underrun  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign w_phase = r_acc + (PHASE_W'(r_diff) << (PHASE_W - SYM_BITS));

    dmpsk_cos_lut #(
        .LUT_AW (LUT_AW),
        .AMP_W  (AMP_W)
    ) u_lut (
        .clk_dds (clk_dds),
        .rstn    (rstn),
        .i_addr  (w_phase[PHASE_W-1 -: LUT_AW]),
        .o_q     (w_lut_q)
    );

    // Output stage, aligned with the ROM latency; idle samples are forced to zero
    always_ff @(posedge clk_dds or negedge rstn) begin
        if (!rstn) begin
            r_vld1 <= 1'b0;
            r_vld2 <= 1'b0;
            r_out  <= {(AMP_W+1){1'b0}};
        end else begin
            r_vld1 <= (r_state == ST_RUN);
            r_vld2 <= r_vld1;
            r_out  <= r_vld1 ? w_lut_q : {(AMP_W+1){1'b0}};
        end
    end

    assign in_ready       = w_ready;
    assign underrun       = w_underrun;
    assign diff_out       = r_diff;
    assign data_valid     = r_vld2;
    assign data_modul_out = r_out;

endmodule

// File: tb/tb_dmpsk_modulator.sv
// Scoreboard bench for dmpsk_modulator with a cycle-indexed reference model.
module tb_dmpsk_modulator;

    localparam int SB   = 2;
    localparam int PW   = 16;
    localparam int LAW  = 8;
    localparam int AW   = 8;
    localparam int SPS  = 50;
    localparam int FCW  = 6554;
    localparam real TB_PI = 3.14159265358979323846;

    logic                 clk_dds = 1'b0;
    logic                 rstn    = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [SB-1:0]        in_data = '0;
    logic [SB-1:0]        diff_out;
    logic signed [AW:0]   data_modul_out;
    logic                 data_valid;
    logic                 underrun;

    dmpsk_modulator #(
        .SYM_BITS (SB), .PHASE_W (PW), .LUT_AW (LAW),
        .AMP_W (AW), .SPS (SPS), .FCW (FCW)
    ) dut (
        .clk_dds        (clk_dds),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .diff_out       (diff_out),
        .data_modul_out (data_modul_out),
        .data_valid     (data_valid),
        .underrun       (underrun)
    );

    always #5 clk_dds = ~clk_dds;

    typedef struct { int period; int value; } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;
    int e_last   = 0;
    bit m_active = 0;
    int m_diff   = 0;
    int n_xfer   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (period %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int map_sym(input int d);
        int b;
`ifdef DMPSK_GRAY_MAP_EN
        b = 0;
        for (int s = d; s != 0; s = s >> 1) b = b ^ s;
`else
        b = d;
`endif
        return b;
    endfunction

    function automatic int ideal_sample(input int period, input int diff);
        longint ph;
        int     addr;
        real    v;
        ph   = (longint'(period) * FCW + longint'(diff) * (1 << (PW - SB))) % (64'd1 << PW);
        addr = int'(ph >> (PW - LAW));
        v    = real'((1 << AW) - 1) * $cos(2.0 * TB_PI * addr / real'(1 << LAW));
        if (v >= 0.0) return $rtoi(v + 0.5);
        else return -$rtoi(0.5 - v);
    endfunction

    function automatic bit model_ready();
        return !m_active || (edge_cnt - e_last >= SPS - 1);
    endfunction

    // Reference model: advances one period per clock, records each accepted symbol
    initial begin
        forever begin
            @(posedge clk_dds or negedge rstn);
            if (!rstn) begin
                edge_cnt = 0; e_last = 0; m_active = 0; m_diff = 0;
                sb.delete();
            end else if (clk_dds) begin
                if (in_valid && model_ready()) begin
                    m_diff   = (m_diff + map_sym(int'(in_data))) % (1 << SB);
                    e_last   = edge_cnt + 1;
                    m_active = 1;
                    n_xfer++;
                    for (int k = 0; k < SPS; k++) begin
                        exp_t e;
                        e.period = e_last + k + 2;
                        e.value  = ideal_sample(e_last + k, m_diff);
                        sb.push_back(e);
                    end
                end
                edge_cnt++;
            end
        end
    end

    // Monitor: compares outputs on the falling edge
    initial begin
        forever begin
            @(negedge clk_dds);
            if (!rstn) begin
                check("rst_out", int'(data_modul_out), 0);
                check("rst_valid", int'(data_valid), 0);
                check("rst_ready", int'(in_ready), 1);
                check("rst_diff", int'(diff_out), 0);
                check("rst_underrun", int'(underrun), 0);
            end else begin
                check("in_ready", int'(in_ready), int'(model_ready()));
                check("underrun", int'(underrun),
                      int'(m_active && (edge_cnt - e_last == SPS - 1) && !in_valid));
                check("diff_out", int'(diff_out), m_diff);
                while (sb.size() > 0 && sb[0].period < edge_cnt) begin
                    check("sample_missing", 0, 1);
                    void'(sb.pop_front());
                end
                if (data_valid) begin
                    if (sb.size() == 0 || sb[0].period != edge_cnt) begin
                        check("sample_unexpected", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sample", int'(data_modul_out), e.value);
                    end
                end else begin
                    check("idle_zero", int'(data_modul_out), 0);
                    if (sb.size() > 0 && sb[0].period == edge_cnt) begin
                        check("sample_missing", 0, 1);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_dds);
        #1;
    endtask

    task automatic wait_xfers(input int target);
        int k = 0;
        while (n_xfer < target && k < 20 * SPS) begin
            tick();
            k++;
        end
        if (n_xfer < target) check("xfer_timeout", n_xfer, target);
    endtask

    task automatic send_sym(input int d);
        in_data  = SB'(d);
        in_valid = 1'b1;
        wait_xfers(n_xfer + 1);
        in_valid = 1'b0;
        in_data  = SB'($urandom);
    endtask

    task automatic do_reset(input int cycles);
        in_valid = 1'b0;
        @(posedge clk_dds);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_valid", int'(data_valid), 0);
        check("async_rst_out", int'(data_modul_out), 0);
        check("async_rst_ready", int'(in_ready), 1);
        check("async_rst_diff", int'(diff_out), 0);
        repeat (cycles) tick();
        rstn = 1'b1;
        check("post_rst_ready", int'(in_ready), 1);
        check("post_rst_diff", int'(diff_out), 0);
    endtask

    initial begin
        repeat (4) tick();
        rstn = 1'b1;

        // back-to-back run of symbol 01
        in_data  = 2'b01;
        in_valid = 1'b1;
        wait_xfers(5);
        in_valid = 1'b0;
        check("b2b_diff", int'(diff_out), 1);
        repeat (SPS + 10) tick();

        // resume after underrun from the held phase
        send_sym(1);
        check("resume_diff", int'(diff_out), 2);
        repeat (SPS + 5) tick();

        // Gray decode from a fresh phase
        do_reset(3);
        send_sym(3);
`ifdef DMPSK_GRAY_MAP_EN
        check("gray_diff", int'(diff_out), 2);
`else
        check("gray_diff", int'(diff_out), 3);
`endif
        repeat (SPS + 5) tick();

        // randomized symbols with random idle gaps
        for (int s = 0; s < 30; s++) begin
            int gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 70)) : 0;
            repeat (gap) tick();
            send_sym(int'($urandom_range(0, (1 << SB) - 1)));
        end
        repeat (SPS + 5) tick();

        // mid-symbol reset abort
        send_sym(2);
        repeat (19) tick();
        do_reset(3);
        repeat (SPS + 5) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmpsk_modulator.md
DMPSK_MODULATOR -- requirements
Module: dmpsk_modulator

Interface
REQ-001 The block SHALL have parameter SYM_BITS, default 2, meaning bits per symbol (legal range 1..4; 2 is DQPSK).
REQ-002 The block SHALL have parameter PHASE_W, default 16, meaning carrier phase accumulator width.
REQ-003 The block SHALL have parameter LUT_AW, default 8, meaning cosine LUT address bits, taken from the top of the phase word.
REQ-004 The block SHALL have parameter AMP_W, default 8, meaning sample magnitude bits.
REQ-005 The block SHALL have parameter SPS, default 50, meaning samples per symbol (>=2).
REQ-006 The block SHALL have parameter FCW, default 6554, meaning per-cycle carrier phase increment.
REQ-007 The block SHALL have port clk_dds, input, width 1, the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rstn, input, width 1, the reset, which is asynchronous and active-low.
REQ-009 The block SHALL have port in_valid, input, width 1, meaning a symbol is offered.
REQ-010 The block SHALL have port in_ready, output, width 1, meaning the block accepts a symbol this cycle.
REQ-011 The block SHALL have port in_data, input, width SYM_BITS, carrying the symbol.
REQ-012 The block SHALL have port diff_out, output, width SYM_BITS, carrying the accumulated differential phase index.
REQ-013 The block SHALL have port data_modul_out, output, width AMP_W+1, carrying the signed two's-complement modulated sample.
REQ-014 The block SHALL have port data_valid, output, width 1, meaning data_modul_out is a live sample.
REQ-015 The block SHALL have port underrun, output, width 1, a one-cycle pulse when no symbol was available at a symbol boundary.

Function
REQ-016 The carrier accumulator acc SHALL add FCW every cycle from reset release and wrap modulo 2^PHASE_W.
REQ-017 The FSM SHALL have states IDLE and RUN, plus a sample counter cnt in the range 0..SPS-1.
REQ-018 in_ready SHALL be 1 in IDLE, and 1 in RUN only when cnt==SPS-1; it SHALL be 0 otherwise.
REQ-019 On a transfer (in_valid&in_ready): diff_reg <= (diff_reg + map(in_data)) mod 2^SYM_BITS, cnt <= 0, state <= RUN.
REQ-020 In RUN with cnt==SPS-1 and no transfer: state <= IDLE, underrun=1 for that one cycle, and diff_reg is held.
REQ-021 In RUN otherwise, cnt SHALL increment by 1.
REQ-022 The phase SHALL be computed as phase = acc + (diff_reg << (PHASE_W-SYM_BITS)) mod 2^PHASE_W, and the LUT address as phase[PHASE_W-1 -: LUT_AW].
REQ-023 data_modul_out SHALL be the registered output of round((2^AMP_W-1)*cos(2*pi*addr/2^LUT_AW)), range +/-(2^AMP_W-1).
REQ-024 The first sample of a symbol SHALL appear 2 cycles after its transfer edge; exactly SPS consecutive data_valid samples per symbol; zero gaps between back-to-back symbols.
REQ-025 When data_valid=0, data_modul_out SHALL be 0.
REQ-026 diff_out SHALL equal diff_reg, updating on the edge after transfer.
REQ-027 For SYM_BITS=1 the block SHALL behave as DBPSK, with no special-casing.

Reset
REQ-028 While rstn=0: acc=0, diff_reg=0, cnt=0, state=IDLE, data_modul_out=0, data_valid=0, underrun=0, diff_out=0, in_ready=1.
REQ-029 An assertion mid-symbol SHALL abort immediately, with no partial symbol completion after release.

Configuration
REQ-030 With DMPSK_GRAY_MAP_EN defined, map() SHALL be Gray-to-binary conversion of in_data (2-bit: 00->0, 01->1, 11->2, 10->3).
REQ-031 Without DMPSK_GRAY_MAP_EN, map() SHALL be the identity (natural binary).

Structure
REQ-032 Package dmpsk_pkg SHALL hold the FSM state enum, the gray2bin function, and the default FCW/SPS constants.
REQ-033 Sub-module dmpsk_cos_lut SHALL be used: a registered ROM (LUT_AW in, AMP_W+1 out) providing one of the 2 latency stages.

Verification
REQ-034 Reset: hold rstn=0 -> data_modul_out=0, data_valid=0, in_ready=1, diff_out=0, underrun=0.
REQ-035 Back-to-back, no macro, SYM_BITS=2: in_data 01 x5 continuously valid -> diff_out 1,2,3,0,1; data_valid high 250 consecutive cycles; in_ready high once per 50 cycles; no underrun.
REQ-036 Phase check, FCW=0, AMP_W=8: symbols 00, 10, 01 -> samples +255 x50, -255 x50, 0 x50 (diff 0, 2, 3).
REQ-037 Underrun: one symbol then in_valid=0 -> 50 valid samples, underrun pulse on cnt==49 cycle, then data_valid=0 and output 0; diff_out held; next symbol 01 resumes from held diff with first sample 2 cycles after transfer.
REQ-038 Gray: from diff 0, in_data=11 -> diff_out=2 with DMPSK_GRAY_MAP_EN and diff_out=3 without.
REQ-039 Mid-symbol reset: rstn low at cnt=20 -> all outputs at reset values asynchronously; after release, in_ready=1 and diff_out=0.
